morse_key_segmenter: RTL and testbench

Time-base driven segmenter that turns the raw Morse key level into per-character symbol packets. It measures mark (key down) and space (key up) durations in `tick` units, classifies marks as dit or dah, and emits one `ce` strobe per completed character and one per word gap. It sits directly upstream of the word decoder, which consumes `dits_dahs`, `len`, `word_end` and `error` on each `ce` pulse.

---
 rtl/morse_key_segmenter.sv | 156 +++++++++++++++
 tb/tb_morse_key_segmenter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_segmenter.sv
// Morse key segmenter: times marks and spaces in tick units, classifies dits/dahs
// and emits one registered strobe per completed character and per word gap.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | key up, nothing pending, no word open
// MARK      | key down, timing the mark
// SPACE_SYM | key up, symbols pending, waiting for char gap
// SPACE_CHR | character emitted, waiting for word gap
module morse_key_segmenter #(
    parameter int MAX_LEN    = 6,
    parameter int LEN_W      = 3,
    parameter int CNT_W      = 6,
    parameter int GLITCH_MAX = 1,
    parameter int DAH_MIN    = 8,
    parameter int MARK_MAX   = 40,
    parameter int CHAR_GAP   = 8,
    parameter int WORD_GAP   = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               key,
    output logic [MAX_LEN-1:0] dits_dahs,
    output logic [LEN_W-1:0]   len,
    output logic               word_end,
    output logic               error,
    output logic               ce
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MARK      = 2'd1,
        SPACE_SYM = 2'd2,
        SPACE_CHR = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] GLITCH_C = CNT_W'(GLITCH_MAX);
    localparam logic [CNT_W-1:0] DAH_C    = CNT_W'(DAH_MIN);
    localparam logic [CNT_W-1:0] MARK_C   = CNT_W'(MARK_MAX);
    localparam logic [CNT_W-1:0] CHR_LAST = CNT_W'(CHAR_GAP - 1);
    localparam logic [CNT_W-1:0] WRD_LAST = CNT_W'(WORD_GAP - 1);
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(MAX_LEN);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
    logic [MAX_LEN-1:0] pend_bits, pend_bits_nxt;
    logic [LEN_W-1:0]   pend_len, pend_len_nxt;
    logic               pend_err, pend_err_nxt;
    logic               chr_strobe, wrd_strobe;

    assign cnt_inc = (tick && (cnt != CNT_MAX)) ? cnt + 1'b1 : cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_bits <= '0;
            pend_len  <= '0;
            pend_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pend_bits <= pend_bits_nxt;
            pend_len  <= pend_len_nxt;
            pend_err  <= pend_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt_inc;
        pend_bits_nxt = pend_bits;
        pend_len_nxt  = pend_len;
        pend_err_nxt  = pend_err;
        chr_strobe    = 1'b0;
        wrd_strobe    = 1'b0;
        case (state)
            IDLE: begin
                if (key) begin
                    state_nxt = MARK;
                    cnt_nxt   = '0;
                end
            end
            MARK: begin
                if (!key) begin
                    cnt_nxt = '0;
                    if (cnt <= GLITCH_C) begin
                        state_nxt = (pend_len == '0) ? IDLE : SPACE_SYM;
                    end else begin
                        state_nxt = SPACE_SYM;
                        if (pend_len == LEN_FULL) begin
                            pend_err_nxt = 1'b1;
                        end else begin
                            pend_bits_nxt = {pend_bits[MAX_LEN-2:0], (cnt >= DAH_C)};
                            pend_len_nxt  = pend_len + 1'b1;
                            if (cnt > MARK_C) pend_err_nxt = 1'b1;
                        end
                    end
                end
            end
            SPACE_SYM: begin
                if (key) begin
                    state_nxt = MARK;
                    cnt_nxt   = '0;
                end else if (tick && (cnt == CHR_LAST)) begin
                    // counter keeps running into SPACE_CHR so the word gap is measured from the last mark
                    chr_strobe    = 1'b1;
                    state_nxt     = SPACE_CHR;
                    pend_bits_nxt = '0;
                    pend_len_nxt  = '0;
                    pend_err_nxt  = 1'b0;
                end
            end
            SPACE_CHR: begin
                if (key) begin
                    state_nxt = MARK;
                    cnt_nxt   = '0;
                end else if (tick && (cnt == WRD_LAST)) begin
                    wrd_strobe = 1'b1;
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce        <= 1'b0;
            dits_dahs <= '0;
            len       <= '0;
            word_end  <= 1'b0;
            error     <= 1'b0;
        end else begin
            ce <= chr_strobe | wrd_strobe;
            if (chr_strobe) begin
                dits_dahs <= pend_bits;
                len       <= pend_len;
                word_end  <= 1'b0;
                error     <= pend_err;
            end else if (wrd_strobe) begin
                dits_dahs <= '0;
                len       <= '0;
                word_end  <= 1'b1;
                error     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_morse_key_segmenter.sv
// Scoreboard bench for morse_key_segmenter: a duration/queue based reference model
// predicts strobes; a negedge monitor compares them against the DUT.
module tb_morse_key_segmenter;

    localparam int MAX_LEN    = 6;
    localparam int LEN_W      = 3;
    localparam int CNT_W      = 6;
    localparam int GLITCH_MAX = 1;
    localparam int DAH_MIN    = 8;
    localparam int MARK_MAX   = 40;
    localparam int CHAR_GAP   = 8;
    localparam int WORD_GAP   = 20;
    localparam int SAT        = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               tick = 1'b0;
    logic               key = 1'b0;
    logic [MAX_LEN-1:0] dits_dahs;
    logic [LEN_W-1:0]   len;
    logic               word_end;
    logic               error;
    logic               ce;

    always #5 clk = ~clk;

    morse_key_segmenter #(
        .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W), .GLITCH_MAX(GLITCH_MAX),
        .DAH_MIN(DAH_MIN), .MARK_MAX(MARK_MAX), .CHAR_GAP(CHAR_GAP), .WORD_GAP(WORD_GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .key(key),
        .dits_dahs(dits_dahs), .len(len), .word_end(word_end), .error(error), .ce(ce)
    );

    typedef struct {
        logic [MAX_LEN-1:0] bits;
        logic [LEN_W-1:0]   len;
        logic               we;
        logic               err;
        int                 cyc;
    } pkt_t;

    pkt_t exp_q[$];
    pkt_t mon_e;
    pkt_t mdl_p;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ce_count = 0;
    logic [MAX_LEN-1:0] last_bits;
    logic [LEN_W-1:0]   last_len;
    logic               last_we, last_err;

    // reference model: mark/space durations in ticks plus a queue of pending symbols
    bit   in_mark = 0;
    bit   word_open = 0;
    bit   perr = 0;
    int   dur = 0;
    bit   pend[$];
    logic [MAX_LEN-1:0] mdl_v;

    function automatic int sat(int d);
        return (d < SAT) ? d + 1 : d;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_mark = 0; word_open = 0; perr = 0; dur = 0;
            pend.delete();
            exp_q.delete();
        end else begin
            cyc++;
            if (in_mark) begin
                if (!key) begin
                    if (dur <= GLITCH_MAX) begin
                        if (pend.size() == 0) word_open = 0;
                    end else if (pend.size() == MAX_LEN) begin
                        perr = 1;
                    end else begin
                        pend.push_back(dur >= DAH_MIN);
                        if (dur > MARK_MAX) perr = 1;
                    end
                    in_mark = 0;
                    dur = 0;
                end else if (tick) dur = sat(dur);
            end else if (key) begin
                in_mark = 1;
                dur = 0;
            end else if (pend.size() > 0) begin
                if (tick && dur + 1 == CHAR_GAP) begin
                    mdl_v = '0;
                    foreach (pend[i]) mdl_v = {mdl_v[MAX_LEN-2:0], pend[i]};
                    mdl_p.bits = mdl_v;
                    mdl_p.len  = LEN_W'(pend.size());
                    mdl_p.we   = 1'b0;
                    mdl_p.err  = perr;
                    mdl_p.cyc  = cyc;
                    exp_q.push_back(mdl_p);
                    pend.delete();
                    perr = 0;
                    word_open = 1;
                end
                if (tick) dur = sat(dur);
            end else if (word_open) begin
                if (tick && dur + 1 == WORD_GAP) begin
                    mdl_p.bits = '0; mdl_p.len = '0; mdl_p.we = 1'b1; mdl_p.err = 1'b0;
                    mdl_p.cyc = cyc;
                    exp_q.push_back(mdl_p);
                    word_open = 0;
                    dur = 0;
                end else if (tick) dur = sat(dur);
            end else if (tick) dur = sat(dur);
        end
    end

    always @(negedge clk) begin
        if (rst_n && ce) begin
            ce_count++;
            last_bits = dits_dahs; last_len = len; last_we = word_end; last_err = error;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_ce: got ce=1 at cycle %0d, expected no strobe", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_cycle", cyc, mon_e.cyc);
                check("dits_dahs", dits_dahs, mon_e.bits);
                check("len", len, mon_e.len);
                check("word_end", word_end, mon_e.we);
                check("error", error, mon_e.err);
            end
        end else if (rst_n && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            total++; bad++;
            $display("FAIL missing_ce: got ce=0 at cycle %0d, expected strobe len=%0d word_end=%0d",
                     cyc, mon_e.len, mon_e.we);
        end
    end

    // rnd=0: tick every cycle; rnd=1: tick on about 3 of 4 cycles
    task automatic seg(logic v, int n, bit rnd);
        repeat (n) begin
            @(negedge clk);
            key  = v;
            tick = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic check_last(string name, int n0, int n, int b, int l, int we, int er);
        check({name, "_count"}, ce_count - n0, n);
        check({name, "_bits"}, last_bits, b);
        check({name, "_len"}, last_len, l);
        check({name, "_we"}, last_we, we);
        check({name, "_err"}, last_err, er);
    endtask

    initial begin
        int n0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ce", ce, 0);
        check("rst_bits", dits_dahs, 0);
        check("rst_len", len, 0);
        check("rst_we", word_end, 0);
        check("rst_err", error, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single dit, then word gap
        n0 = ce_count;
        seg(1, 4, 0); seg(0, 12, 0); settle();
        check_last("dit", n0, 1, 0, 1, 0, 0);
        seg(0, 10, 0); settle();
        check_last("word", n0, 2, 0, 0, 1, 0);

        // dah-dit-dah
        n0 = ce_count;
        seg(1, 10, 0); seg(0, 3, 0); seg(1, 4, 0); seg(0, 3, 0); seg(1, 10, 0); seg(0, 11, 0);
        settle();
        check_last("ddd", n0, 1, 5, 3, 0, 0);
        seg(0, 15, 0);

        // glitch only: no strobes
        n0 = ce_count;
        seg(1, 1, 0); seg(0, 30, 0); settle();
        check("glitch_count", ce_count - n0, 0);

        // symbol overflow, then a clean character in the same word
        n0 = ce_count;
        repeat (7) begin seg(1, 4, 0); seg(0, 3, 0); end
        seg(0, 10, 0); settle();
        check_last("ovf", n0, 1, 0, 6, 0, 1);
        seg(1, 4, 0); seg(0, 10, 0); settle();
        check_last("after_ovf", n0, 2, 0, 1, 0, 0);
        seg(0, 20, 0);

        // over-long mark
        n0 = ce_count;
        seg(1, 50, 0); seg(0, 10, 0); settle();
        check_last("long", n0, 1, 1, 1, 0, 1);
        seg(0, 20, 0); settle();
        check("long_word_we", last_we, 1);

        // reset mid-mark discards pending symbols
        seg(1, 4, 0); seg(0, 3, 0); seg(1, 4, 0); seg(0, 3, 0); seg(1, 3, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ce", ce, 0);
        check("midrst_we", word_end, 0);
        check("midrst_len", len, 0);
        check("midrst_bits", dits_dahs, 0);
        check("midrst_err", error, 0);
        key = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n0 = ce_count;
        seg(0, 30, 0); settle();
        check("post_rst_count", ce_count - n0, 0);

        // randomized marks, spaces and tick pattern
        repeat (150) begin
            seg(1, $urandom_range(1, 50), 1);
            seg(0, $urandom_range(1, 45), 1);
        end
        seg(0, 80, 0); settle();
        check("drain_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end of test, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
